frame_aligner: RTL and testbench

- Sits directly downstream of the clk40-domain 32-bit deserializer.
- Input words carry an arbitrary bit phase relative to the transmitter's word boundary, because the deserializer performs no alignment.
- The block searches all 32 bit offsets for a periodic sync word, confirms the offset, and locks. It then emits word-aligned data with a start-of-frame marker, lock status and the chosen offset.

---
 rtl/frame_align_pkg.sv | 21 ++
 rtl/sync_search.sv | 28 ++
 rtl/frame_aligner.sv | 149 ++++++++++++++
 tb/tb_frame_aligner.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_align_pkg.sv
// Shared types and helpers for the frame aligner: FSM states, default sync word, window slicer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frame_align_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hBC5A_3C96;

  // Candidate at offset k is w[63-k -: 32], i.e. bits 63-k..32-k of the window.
  function automatic logic [31:0] slice_window(input logic [63:0] w, input logic [4:0] k);
    logic [63:0] sh;
    sh = w >> (6'd32 - {1'b0, k});
    return sh[31:0];
  endfunction

endpackage

// File: rtl/sync_search.sv
// Compares all 32 window offsets against the sync word; reports the lowest matching offset.
// Latency: combinational.
// Backpressure: none.
module sync_search
  import frame_align_pkg::*;
(
  input  logic [63:0] window,
  input  logic [31:0] sync_word,
  output logic        hit,
  output logic [4:0]  hit_offset
);

  logic [31:0] match;

  for (genvar k = 0; k < 32; k++) begin : g_cmp
    assign match[k] = (slice_window(window, 5'(k)) == sync_word);
  end

  // Walk from the top down so the lowest matching offset is the one left standing.
  always_comb begin
    hit        = |match;
    hit_offset = '0;
    for (int k = 31; k >= 0; k--) begin
      if (match[k]) hit_offset = 5'(k);
    end
  end

endmodule

// File: rtl/frame_aligner.sv
// Word aligner: finds the periodic sync word at any of 32 bit offsets, verifies, locks, emits aligned words.
// Latency: 1 cycle din->dout. Optional stats ports under FRAME_ALIGNER_STATS_EN.
// Backpressure: none; accepts a word every clk40 cycle, dout_valid qualifies output.
module frame_aligner
  import frame_align_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEFAULT,
  parameter int          FRAME_LEN = 16,
  parameter int          LOCK_CNT  = 4,
  parameter int          MISS_MAX  = 3
) (
  input  logic        clk40,
  input  logic        rst,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        dout_valid,
  output logic        sof,
  output logic        locked,
  output logic [4:0]  bit_offset
`ifdef FRAME_ALIGNER_STATS_EN
  ,
  output logic [15:0] lock_loss_cnt,
  output logic [15:0] miss_total
`endif
);

  localparam int            FW         = $clog2(FRAME_LEN);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);
  localparam logic [3:0]    LOCK_TGT   = 4'(LOCK_CNT);
  localparam logic [3:0]    MISS_TGT   = 4'(MISS_MAX);

  state_t        state;
  logic [31:0]   prev;
  logic [63:0]   win;
  logic [FW-1:0] frame_cnt;
  logic [3:0]    hit_cnt;
  logic [3:0]    miss_cnt;
  logic          srch_hit;
  logic [4:0]    srch_off;
  logic [31:0]   cand;
  logic          at_boundary;
  logic          cand_match;
  logic          lock_miss;
  logic          lock_drop;

  assign win         = {prev, din};
  assign cand        = slice_window(win, bit_offset);
  assign at_boundary = (frame_cnt == '0);
  assign cand_match  = (cand == SYNC_WORD);
  assign lock_miss   = (state == LOCKED) && at_boundary && !cand_match;
  assign lock_drop   = lock_miss && ((miss_cnt + 4'd1) == MISS_TGT);

  sync_search u_sync_search (
    .window     (win),
    .sync_word  (SYNC_WORD),
    .hit        (srch_hit),
    .hit_offset (srch_off)
  );

  always_ff @(posedge clk40) begin
    if (rst) begin
      state      <= SEARCH;
      prev       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sof        <= 1'b0;
      locked     <= 1'b0;
      bit_offset <= '0;
      frame_cnt  <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      prev       <= din;
      dout       <= cand;
      sof        <= 1'b0;
      dout_valid <= 1'b0;
      frame_cnt  <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;

      case (state)
        SEARCH: begin
          if (srch_hit) begin
            bit_offset <= srch_off;
            frame_cnt  <= FW'(1);
            hit_cnt    <= 4'd1;
            if (LOCK_TGT == 4'd1) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              miss_cnt <= '0;
            end else begin
              state <= VERIFY;
            end
          end
        end

        VERIFY: begin
          if (at_boundary) begin
            if (cand_match) begin
              hit_cnt <= hit_cnt + 4'd1;
              if ((hit_cnt + 4'd1) == LOCK_TGT) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else begin
              state   <= SEARCH;
              hit_cnt <= '0;
            end
          end
        end

        LOCKED: begin
          // valid is withheld on the word that coincides with dropping lock
          dout_valid <= !lock_drop;
          if (at_boundary) begin
            if (cand_match) begin
              sof      <= 1'b1;
              miss_cnt <= '0;
            end else begin
              miss_cnt <= miss_cnt + 4'd1;
            end
          end
          if (lock_drop) begin
            state   <= SEARCH;
            locked  <= 1'b0;
            hit_cnt <= '0;
          end
        end

        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRAME_ALIGNER_STATS_EN
  always_ff @(posedge clk40) begin
    if (rst) begin
      lock_loss_cnt <= '0;
      miss_total    <= '0;
    end else begin
      if (lock_drop && (lock_loss_cnt != 16'hFFFF)) lock_loss_cnt <= lock_loss_cnt + 16'd1;
      if (lock_miss && (miss_total != 16'hFFFF))    miss_total    <= miss_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_aligner.sv
// Directed bench for frame_aligner: lock at several offsets, false hit, miss tolerance, reset, stats.
// Expected timing is derived by hand from the sync positions in each generated stream.
module tb_frame_aligner;

  localparam logic [31:0] SYNC = 32'hBC5A_3C96;
  localparam logic [31:0] BAD  = 32'hBC5A_3D96;

  logic        clk40 = 1'b0;
  logic        rst   = 1'b0;
  logic [31:0] din   = '0;
  logic [31:0] dout;
  logic        dout_valid;
  logic        sof;
  logic        locked;
  logic [4:0]  bit_offset;
`ifdef FRAME_ALIGNER_STATS_EN
  logic [15:0] lock_loss_cnt;
  logic [15:0] miss_total;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] tx      [0:255];
  logic [31:0] din_arr [0:255];
  logic [31:0] obs_dout  [0:255];
  logic        obs_valid [0:255];
  logic        obs_sof   [0:255];
  logic        obs_lock  [0:255];
  logic [4:0]  obs_off   [0:255];

  frame_aligner dut (
    .clk40      (clk40),
    .rst        (rst),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sof        (sof),
    .locked     (locked),
    .bit_offset (bit_offset)
`ifdef FRAME_ALIGNER_STATS_EN
    ,
    .lock_loss_cnt (lock_loss_cnt),
    .miss_total    (miss_total)
`endif
  );

  always #5 clk40 = ~clk40;

  // Transmit frames of 16 words, sync word at every multiple of 16.
  task automatic fill_tx(input int n);
    for (int j = 0; j < 256; j++) tx[j] = '0;
    for (int j = 0; j < n; j++)
      tx[j] = (j % 16 == 0) ? SYNC : (32'h2468_ACE0 + 32'(j) * 32'h9E37_79B9);
  endtask

  // Bit-shift the transmit stream so its words sit at offset k of the DUT window.
  task automatic build_din(input int k, input int base, input int n);
    logic [63:0] x;
    for (int m = 0; m < n; m++) begin
      x = {((m == 0) ? 32'h0 : tx[m-1]), tx[m]} >> k;
      din_arr[base + m] = x[31:0];
    end
  endtask

  task automatic clear_din();
    for (int n = 0; n < 256; n++) din_arr[n] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din = '0;
    @(posedge clk40);
    #1;
    rst = 1'b0;
  endtask

  // Drive din_arr[0..nwords-1]; obs[n] is sampled just after the edge that captured din_arr[n].
  task automatic play(input int nwords, input int rst_at);
    for (int n = 0; n < nwords; n++) begin
      din = din_arr[n];
      rst = (n == rst_at);
      @(posedge clk40);
      #1;
      obs_dout[n]  = dout;
      obs_valid[n] = dout_valid;
      obs_sof[n]   = sof;
      obs_lock[n]  = locked;
      obs_off[n]   = bit_offset;
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    din = 32'hDEAD_BEEF;
    rst = 1'b1;
    @(posedge clk40);
    #1;
    checks++; if (dout !== 32'h0)   begin errors++; $display("FAIL reset_dout got=%h exp=0", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
    checks++; if (sof !== 1'b0)     begin errors++; $display("FAIL reset_sof got=%b exp=0", sof); end
    checks++; if (locked !== 1'b0)  begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (bit_offset !== 5'd0) begin errors++; $display("FAIL reset_offset got=%0d exp=0", bit_offset); end
    rst = 1'b0;
    din = '0;
  endtask

  // Sync tx[0] is seen at edge 1; hits at 1,17,33,49 -> locked after edge 49, valid from edge 50.
  task automatic test_lock(input int k);
    int bad;
    int nsof;
    do_reset();
    fill_tx(100);
    clear_din();
    build_din(k, 0, 100);
    play(100, -1);
    checks++; if (obs_off[1] !== 5'(k)) begin errors++; $display("FAIL lock%0d_offset got=%0d exp=%0d", k, obs_off[1], k); end
    checks++; if (obs_lock[48] !== 1'b0) begin errors++; $display("FAIL lock%0d_early got=%b exp=0", k, obs_lock[48]); end
    checks++; if (obs_lock[49] !== 1'b1) begin errors++; $display("FAIL lock%0d_locked got=%b exp=1", k, obs_lock[49]); end
    bad = 0;
    for (int n = 0; n < 50; n++) if (obs_valid[n] !== 1'b0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL lock%0d_valid_pre got=%0d exp=0 early valid words", k, bad); end
    checks++; if (obs_valid[50] !== 1'b1) begin errors++; $display("FAIL lock%0d_valid got=%b exp=1", k, obs_valid[50]); end
    nsof = 0;
    for (int n = 0; n < 100; n++) if (obs_sof[n] === 1'b1) nsof++;
    checks++; if (nsof != 3) begin errors++; $display("FAIL lock%0d_sof_count got=%0d exp=3", k, nsof); end
    checks++; if (obs_sof[65] !== 1'b1 || obs_dout[65] !== SYNC)
      begin errors++; $display("FAIL lock%0d_sof_word got sof=%b dout=%h exp sof=1 dout=%h", k, obs_sof[65], obs_dout[65], SYNC); end
    bad = 0;
    for (int n = 50; n < 100; n++) if (obs_dout[n] !== tx[n-1]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL lock%0d_dout got=%0d exp=0 wrong words", k, bad); end
  endtask

  // Lone sync at offset 5 (hit at edge 5) fails verify at edge 21; real stream at offset 20 starts at n=30.
  task automatic test_false_hit();
    int bad;
    logic [31:0] s;
    do_reset();
    clear_din();
    s = SYNC;
    din_arr[4] = {5'b0, s[31:5]};
    din_arr[5] = {s[4:0], 27'b0};
    fill_tx(100);
    build_din(20, 30, 100);
    play(130, -1);
    checks++; if (obs_off[5] !== 5'd5) begin errors++; $display("FAIL false_offset got=%0d exp=5", obs_off[5]); end
    checks++; if (obs_off[30] !== 5'd5) begin errors++; $display("FAIL false_hold got=%0d exp=5", obs_off[30]); end
    checks++; if (obs_off[31] !== 5'd20) begin errors++; $display("FAIL false_real_offset got=%0d exp=20", obs_off[31]); end
    checks++; if (obs_lock[78] !== 1'b0 || obs_lock[79] !== 1'b1)
      begin errors++; $display("FAIL false_lock got=%b%b exp=01", obs_lock[78], obs_lock[79]); end
    bad = 0;
    for (int n = 0; n < 80; n++) if (obs_valid[n] !== 1'b0 || obs_lock[n] !== (n >= 79)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL false_prelock got=%0d exp=0 bad cycles", bad); end
    bad = 0;
    for (int n = 80; n < 130; n++) if (obs_dout[n] !== tx[n-31] || obs_valid[n] !== 1'b1) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL false_dout got=%0d exp=0 wrong words", bad); end
  endtask

  // Locked from edge 49; syncs 64,80 corrupt, 96 good, then 112,128,144 corrupt -> drop at edge 145.
  task automatic test_miss();
    do_reset();
    fill_tx(150);
    tx[64] = BAD; tx[80] = BAD; tx[112] = BAD; tx[128] = BAD; tx[144] = BAD;
    clear_din();
    build_din(9, 0, 150);
    play(150, -1);
    checks++; if (obs_sof[65] !== 1'b0 || obs_sof[81] !== 1'b0)
      begin errors++; $display("FAIL miss_sof got=%b%b exp=00", obs_sof[65], obs_sof[81]); end
    checks++; if (obs_lock[96] !== 1'b1) begin errors++; $display("FAIL miss_hold got=%b exp=1", obs_lock[96]); end
    checks++; if (obs_sof[97] !== 1'b1) begin errors++; $display("FAIL miss_good_sof got=%b exp=1", obs_sof[97]); end
    checks++; if (obs_lock[144] !== 1'b1 || obs_valid[144] !== 1'b1)
      begin errors++; $display("FAIL miss_pre_drop got lock=%b valid=%b exp 1 1", obs_lock[144], obs_valid[144]); end
    checks++; if (obs_lock[145] !== 1'b0 || obs_valid[145] !== 1'b0)
      begin errors++; $display("FAIL miss_drop got lock=%b valid=%b exp 0 0", obs_lock[145], obs_valid[145]); end
    checks++; if (obs_off[149] !== 5'd9) begin errors++; $display("FAIL miss_offset_hold got=%0d exp=9", obs_off[149]); end
  endtask

  // Reset at n=70 while locked; relock from sync tx[80] (edge 81) to edge 129.
  task automatic test_reset_mid_lock();
    do_reset();
    fill_tx(135);
    clear_din();
    build_din(13, 0, 135);
    play(135, 70);
    checks++; if (obs_lock[69] !== 1'b1) begin errors++; $display("FAIL rstlk_pre got=%b exp=1", obs_lock[69]); end
    checks++; if (obs_dout[70] !== 32'h0 || obs_valid[70] !== 1'b0 || obs_sof[70] !== 1'b0 ||
                  obs_lock[70] !== 1'b0 || obs_off[70] !== 5'd0)
      begin errors++; $display("FAIL rstlk_clear got dout=%h v=%b sof=%b lk=%b off=%0d exp all 0",
                               obs_dout[70], obs_valid[70], obs_sof[70], obs_lock[70], obs_off[70]); end
    checks++; if (obs_off[81] !== 5'd13) begin errors++; $display("FAIL rstlk_offset got=%0d exp=13", obs_off[81]); end
    checks++; if (obs_lock[128] !== 1'b0 || obs_lock[129] !== 1'b1)
      begin errors++; $display("FAIL rstlk_relock got=%b%b exp=01", obs_lock[128], obs_lock[129]); end
  endtask

`ifdef FRAME_ALIGNER_STATS_EN
  // Lose lock at edges 97 and 209, three misses each.
  task automatic test_stats();
    do_reset();
    fill_tx(215);
    tx[64] = BAD; tx[80] = BAD; tx[96] = BAD;
    tx[176] = BAD; tx[192] = BAD; tx[208] = BAD;
    clear_din();
    build_din(22, 0, 215);
    play(215, -1);
    checks++; if (obs_lock[161] !== 1'b1) begin errors++; $display("FAIL stats_relock got=%b exp=1", obs_lock[161]); end
    checks++; if (lock_loss_cnt !== 16'd2) begin errors++; $display("FAIL stats_loss got=%0d exp=2", lock_loss_cnt); end
    checks++; if (miss_total !== 16'd6) begin errors++; $display("FAIL stats_miss got=%0d exp=6", miss_total); end
  endtask
`endif

  initial begin
    test_reset();
    test_lock(13);
    test_lock(0);
    test_lock(31);
    test_false_hit();
    test_miss();
    test_reset_mid_lock();
`ifdef FRAME_ALIGNER_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
